// File: rtl/morse_shift_ctrl_pkg.sv
// Shared types and constants for the Morse shift-chain controller:
// FSM state encoding, letter patterns and default sizing.
package morse_shift_ctrl_pkg;

    localparam int DEFAULT_WIDTH    = 14;
    localparam int DEFAULT_TICK_DIV = 25000000;

    // Widest pattern (C) is 11 bits; entries are stored padded to the default chain length.
    localparam int PAT_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        LTR_A = 3'd0,
        LTR_B = 3'd1,
        LTR_C = 3'd2,
        LTR_D = 3'd3,
        LTR_E = 3'd4,
        LTR_F = 3'd5,
        LTR_G = 3'd6,
        LTR_H = 3'd7
    } letter_e;

    // Bit 0 is the first symbol on the wire: dot=1, dash=111, gap=0.
    localparam logic [PAT_W-1:0] PAT_A = 14'h001D;
    localparam logic [PAT_W-1:0] PAT_B = 14'h0157;
    localparam logic [PAT_W-1:0] PAT_C = 14'h05D7;
    localparam logic [PAT_W-1:0] PAT_D = 14'h0057;
    localparam logic [PAT_W-1:0] PAT_E = 14'h0001;
    localparam logic [PAT_W-1:0] PAT_F = 14'h0175;
    localparam logic [PAT_W-1:0] PAT_G = 14'h0177;
    localparam logic [PAT_W-1:0] PAT_H = 14'h0055;

    function automatic logic [PAT_W-1:0] pattern_of(input logic [2:0] letter);
        logic [PAT_W-1:0] pat;
        pat = '0;
        case (letter_e'(letter))
            LTR_A:   pat = PAT_A;
            LTR_B:   pat = PAT_B;
            LTR_C:   pat = PAT_C;
            LTR_D:   pat = PAT_D;
            LTR_E:   pat = PAT_E;
            LTR_F:   pat = PAT_F;
            LTR_G:   pat = PAT_G;
            LTR_H:   pat = PAT_H;
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/morse_shift_ctrl_rate_divider.sv
// Modulo-TICK_DIV counter that advances while enabled, clears on demand,
// and flags the last count of each period with a one-cycle tick.
module morse_shift_ctrl_rate_divider
    import morse_shift_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/morse_shift_ctrl.sv
// Drives a WIDTH-long shift chain with a Morse letter pattern: one parallel
// load, then WIDTH evenly paced shift pulses, then a done pulse.
module morse_shift_ctrl
    import morse_shift_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] load_val,
    output logic             load_n,
    output logic             shift,
    output logic             fill,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] load_val_q;
    logic [WIDTH-1:0] load_val_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [BIT_W-1:0] bit_cnt_d;

    logic div_clr;
    logic div_en;
    logic tick;

    assign div_clr = (state_q == ST_LOAD);
    assign div_en  = (state_q == ST_RUN);

    morse_shift_ctrl_rate_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (div_clr),
        .en      (div_en),
        .tick    (tick)
    );

    // The pattern itself is captured on acceptance, so it is already valid
    // during the LOAD cycle and stays put until the next accepted start.
    always_comb begin
        state_d    = state_q;
        load_val_d = load_val_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_val_d = WIDTH'(pattern_of(sel));
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        load_n = 1'b1;
        shift  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_n = 1'b0;
                busy   = 1'b1;
            end
            ST_RUN: begin
                busy  = 1'b1;
                shift = tick;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                load_n = 1'b1;
            end
        endcase
    end

    assign load_val = load_val_q;
    assign fill     = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            load_val_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            load_val_q <= load_val_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_morse_shift_ctrl.sv
// Self-checking bench for morse_shift_ctrl: a timeline model of each
// transmission plus a chain model that reconstructs the transmitted bits.
module tb_morse_shift_ctrl;

    localparam int W       = 14;
    localparam int TD      = 4;
    localparam int RUN_LEN = W * TD;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   sel;
    logic [W-1:0] load_val;
    logic         load_n;
    logic         shift;
    logic         fill;
    logic         busy;
    logic         done;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    morse_shift_ctrl #(
        .WIDTH    (W),
        .TICK_DIV (TD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sel      (sel),
        .load_val (load_val),
        .load_n   (load_n),
        .shift    (shift),
        .fill     (fill),
        .busy     (busy),
        .done     (done)
    );

    always @(negedge clk) begin
        compared++;
        if (shift === 1'b1 && load_n === 1'b0) begin
            mismatched++;
            $display("FAIL invariant_shift_load: shift=%b load_n=%b required not both active at %0t", shift, load_n, $time);
        end
        compared++;
        if (fill !== 1'b0) begin
            mismatched++;
            $display("FAIL invariant_fill: fill=%b required 0 at %0t", fill, $time);
        end
    end

    function automatic logic [W-1:0] pattern_from_string(input int letter);
        string        s;
        logic [W-1:0] p;
        p = '0;
        case (letter)
            0:       s = "10111";
            1:       s = "111010101";
            2:       s = "11101011101";
            3:       s = "1110101";
            4:       s = "1";
            5:       s = "101011101";
            6:       s = "111011101";
            default: s = "1010101";
        endcase
        for (int i = 0; i < s.len(); i++) begin
            if (s.getc(i) == "1") p[i] = 1'b1;
        end
        return p;
    endfunction

    // Must be entered at a negedge with the DUT idle; leaves at a negedge, idle again.
    task automatic run_letter(input int letter, input logic [W-1:0] exp_pat, input int alt_sel);
        logic [W-1:0] chain, seen_val, mid_val, recv;
        int loads, load_at, busy_n, nshift, bad_gap, dones, done_at;
        chain = '0; seen_val = '0; mid_val = '0; recv = '0;
        loads = 0; load_at = -1; busy_n = 0; nshift = 0; bad_gap = 0; dones = 0; done_at = -1;
        start = 1'b1;
        sel   = 3'(letter);
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 70; n++) begin
            if (load_n === 1'b0) begin
                loads++;
                load_at  = n;
                seen_val = load_val;
            end
            if (busy === 1'b1) busy_n++;
            if (shift === 1'b1) begin
                if (n != TD * (nshift + 1)) bad_gap++;
                if (nshift < W) recv[nshift] = chain[0];
                nshift++;
            end
            if (done === 1'b1) begin
                dones++;
                done_at = n;
            end
            if (load_n === 1'b0) chain = load_val;
            else if (shift === 1'b1) chain = {fill, chain[W-1:1]};
            if (n == 20 && alt_sel >= 0) sel = 3'(alt_sel);
            if (n == 30) mid_val = load_val;
            @(negedge clk);
        end
        compared++;
        if (loads != 1) begin mismatched++; $display("FAIL load_count L%0d: got %0d required 1", letter, loads); end
        compared++;
        if (load_at != 0) begin mismatched++; $display("FAIL load_latency L%0d: got %0d required 0", letter, load_at); end
        compared++;
        if (seen_val !== exp_pat) begin mismatched++; $display("FAIL load_val L%0d: got %h required %h", letter, seen_val, exp_pat); end
        compared++;
        if (mid_val !== exp_pat) begin mismatched++; $display("FAIL load_val_hold L%0d: got %h required %h", letter, mid_val, exp_pat); end
        compared++;
        if (nshift != W) begin mismatched++; $display("FAIL shift_count L%0d: got %0d required %0d", letter, nshift, W); end
        compared++;
        if (bad_gap != 0) begin mismatched++; $display("FAIL shift_spacing L%0d: got %0d misplaced required 0", letter, bad_gap); end
        compared++;
        if (dones != 1) begin mismatched++; $display("FAIL done_count L%0d: got %0d required 1", letter, dones); end
        compared++;
        if (done_at != RUN_LEN + 1) begin mismatched++; $display("FAIL done_latency L%0d: got %0d required %0d", letter, done_at, RUN_LEN + 1); end
        compared++;
        if (busy_n != RUN_LEN + 1) begin mismatched++; $display("FAIL busy_len L%0d: got %0d required %0d", letter, busy_n, RUN_LEN + 1); end
        compared++;
        if (recv !== exp_pat) begin mismatched++; $display("FAIL chain_out L%0d: got %h required %h", letter, recv, exp_pat); end
        $display("txn letter=%0d alt_sel=%0d load_val=%h shifts=%0d done_at=%0d busy=%0d chain_bits=%h",
                 letter, alt_sel, seen_val, nshift, done_at, busy_n, recv);
    endtask

    task automatic test_reset();
        int shifts, busies, loads, dones;
        reset_n = 1'b0;
        start   = 1'b0;
        sel     = 3'd0;
        repeat (3) @(negedge clk);
        compared++;
        if (load_n !== 1'b1) begin mismatched++; $display("FAIL reset_load_n: got %b required 1", load_n); end
        compared++;
        if (shift !== 1'b0) begin mismatched++; $display("FAIL reset_shift: got %b required 0", shift); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", done); end
        compared++;
        if (load_val !== '0) begin mismatched++; $display("FAIL reset_load_val: got %h required 0", load_val); end
        reset_n = 1'b1;
        shifts = 0; busies = 0; loads = 0; dones = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (shift !== 1'b0) shifts++;
            if (busy !== 1'b0) busies++;
            if (load_n !== 1'b1) loads++;
            if (done !== 1'b0) dones++;
        end
        compared++;
        if (shifts + busies + loads + dones != 0) begin
            mismatched++;
            $display("FAIL idle_quiet: shift=%0d busy=%0d load=%0d done=%0d required all 0", shifts, busies, loads, dones);
        end
        $display("txn reset_idle cycles=100 activity=%0d", shifts + busies + loads + dones);
    endtask

    task automatic test_letters();
        run_letter(0, 14'h001D, -1);
        run_letter(4, 14'h0001, -1);
        run_letter(7, 14'h0055, 2);
        for (int l = 0; l < 8; l++) run_letter(l, pattern_from_string(l), -1);
    endtask

    task automatic test_back_to_back();
        int           load_idx[$];
        logic [W-1:0] load_vals[$];
        int           done_idx[$];
        logic [W-1:0] v58, exp_v;
        v58   = '0;
        start = 1'b1;
        sel   = 3'd3;
        @(negedge clk);
        for (int n = 0; n < 121; n++) begin
            if (load_n === 1'b0) begin
                load_idx.push_back(n);
                load_vals.push_back(load_val);
            end
            if (done === 1'b1) done_idx.push_back(n);
            if (n == 10) sel = 3'd5;
            if (n == 58) v58 = load_val;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (65) @(negedge clk);
        compared++;
        if (load_idx.size() != 3) begin mismatched++; $display("FAIL held_load_count: got %0d required 3", load_idx.size()); end
        for (int k = 0; k < load_idx.size() && k < 3; k++) begin
            exp_v = pattern_from_string(k == 0 ? 3 : 5);
            compared++;
            if (load_idx[k] != k * (RUN_LEN + 3)) begin
                mismatched++; $display("FAIL held_load_at%0d: got %0d required %0d", k, load_idx[k], k * (RUN_LEN + 3));
            end
            compared++;
            if (load_vals[k] !== exp_v) begin
                mismatched++; $display("FAIL held_load_val%0d: got %h required %h", k, load_vals[k], exp_v);
            end
        end
        compared++;
        if (done_idx.size() != 2) begin mismatched++; $display("FAIL held_done_count: got %0d required 2", done_idx.size()); end
        for (int k = 0; k < done_idx.size() && k < 2; k++) begin
            compared++;
            if (done_idx[k] != k * (RUN_LEN + 3) + RUN_LEN + 1) begin
                mismatched++; $display("FAIL held_done_at%0d: got %0d required %0d", k, done_idx[k], k * (RUN_LEN + 3) + RUN_LEN + 1);
            end
        end
        compared++;
        if (v58 !== pattern_from_string(3)) begin mismatched++; $display("FAIL held_sel_ignored: got %h required %h", v58, pattern_from_string(3)); end
        $display("txn start_held loads=%0d dones=%0d idle_val=%h", load_idx.size(), done_idx.size(), v58);
    endtask

    task automatic test_random();
        int letter, gap, alt;
        repeat (8) begin
            letter = int'($urandom_range(0, 7));
            gap    = int'($urandom_range(0, 4));
            alt    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            repeat (gap) @(negedge clk);
            run_letter(letter, pattern_from_string(letter), alt);
        end
    endtask

    task automatic test_reset_mid_run();
        int nshift, cyc, activity;
        nshift = 0; cyc = 0; activity = 0;
        start = 1'b1;
        sel   = 3'd0;
        @(negedge clk);
        start = 1'b0;
        while (nshift < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (shift === 1'b1) nshift++;
        end
        compared++;
        if (nshift != 5) begin mismatched++; $display("FAIL midrun_reach: got %0d shifts required 5", nshift); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL async_busy: got %b required 0", busy); end
        compared++;
        if (load_n !== 1'b1) begin mismatched++; $display("FAIL async_load_n: got %b required 1", load_n); end
        compared++;
        if (shift !== 1'b0) begin mismatched++; $display("FAIL async_shift: got %b required 0", shift); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL async_done: got %b required 0", done); end
        compared++;
        if (load_val !== '0) begin mismatched++; $display("FAIL async_load_val: got %h required 0", load_val); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (shift !== 1'b0 || busy !== 1'b0 || load_n !== 1'b1 || done !== 1'b0) activity++;
        end
        compared++;
        if (activity != 0) begin mismatched++; $display("FAIL post_reset_quiet: got %0d active cycles required 0", activity); end
        $display("txn reset_mid_run shifts_before=%0d post_activity=%0d", nshift, activity);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sel     = 3'd0;
        test_reset();
        test_letters();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/morse_shift_ctrl.md
Name: morse_shift_ctrl

Overview:
- Control stage directly upstream of the per-bit shift-register chain (a WIDTH-long chain of shifterBit cells).
- Looks up a Morse pattern for the selected letter and drives the chain's parallel-load value, active-low load strobe, shift enable and serial fill bit.
- Paces shifting with an internal rate divider so the chain's output bit drives an LED at a human-visible rate.
- Reports busy/done to the top level.

Parameters:
- WIDTH, 14: chain length in bits; all patterns are zero-padded to WIDTH.
- TICK_DIV, 25000000: clk cycles per transmitted bit (0.5 s at 50 MHz); must be ≥2; benches use 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request transmission; level-sampled, acted on only in IDLE.
- sel  in  3  letter select: 0=A … 7=H; sampled in the cycle start is accepted.
- load_val  out  WIDTH  parallel pattern to chain; bit i is the i-th transmitted bit; bit 0 loads into the output-end cell.
- load_n  out  1  active-low load strobe to every cell.
- shift  out  1  shift-enable to every cell; one-cycle pulse per bit period.
- fill  out  1  serial input to the input-end cell; constant 0.
- busy  out  1  high from LOAD through RUN.
- done  out  1  one-cycle pulse after the final shift.

Behaviour:
- Reset (async, reset_n=0):
  - State to IDLE.
  - Divider and bit counter cleared.
  - load_val=0, load_n=1, shift=0, fill=0, busy=0, done=0.
  - Reset mid-transmission aborts immediately. The chain contents are not this block's concern.
- Letter encoding: dot=1, dash=111, 0 between elements, zero-padded, first transmitted symbol in bit 0.
  - A 10111
  - B 111010101
  - C 11101011101
  - D 1110101
  - E 1
  - F 101011101
  - G 111011101
  - H 1010101
- States:
  - IDLE: load_n=1, shift=0. If start=1, latch sel and go to LOAD.
  - LOAD (one cycle):
    - load_n=0 and load_val=pattern(latched sel); busy=1.
    - Clear divider and bit counter; go to RUN.
    - load_val holds the pattern until the next LOAD.
  - RUN:
    - Divider counts 0..TICK_DIV-1.
    - At TICK_DIV-1: shift=1 for that cycle, divider wraps to 0, bit counter increments.
    - When the bit counter reaches WIDTH (WIDTH shifts issued), go to DONE.
    - load_n stays 1.
  - DONE (one cycle): done=1, busy=0, then IDLE.
- Latency:
  - load_n is low in the cycle after start is sampled.
  - The first shift pulse occurs TICK_DIV cycles after the LOAD cycle.
  - The last shift occurs WIDTH·TICK_DIV cycles after LOAD.
  - done occurs the cycle after the last shift.
- Simultaneous and boundary events:
  - start held high: re-triggers from IDLE after DONE; no back-to-back LOAD without passing DONE.
  - start or sel changes during LOAD/RUN/DONE are ignored.
  - shift and load_n are never active in the same cycle.
- Widths:
  - Divider is ceil(log2(TICK_DIV)) bits.
  - Bit counter is ceil(log2(WIDTH+1)) bits.
  - Divider and bit counter wrap only as described; no overflow is possible.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOAD, RUN, DONE);
  - letter-to-pattern constants (8 entries, WIDTH bits each);
  - default WIDTH/TICK_DIV constants.
- One natural sub-module: rate_divider (enable-gated, clear-able modulo-TICK_DIV counter with a one-cycle tick output).

Test Plan:
- Reset, then release with start=0 → all outputs at reset values; no shift pulses for 100 cycles.
- TICK_DIV=4, sel=0 (A), one-cycle start:
  - load_n=0 for exactly one cycle with load_val=14'h001D.
  - 14 shift pulses spaced 4 cycles apart; the first is 4 cycles after load.
  - done pulse 1 cycle after the last shift.
  - A chain model outputs 1,0,1,1,1 then 0s.
- sel=4 (E) → load_val=14'h0001; sel=7 (H) → 14'h0055. In both cases busy is high for 1+14·4 cycles.
- start held high continuously, sel=3 → repeated transmissions, each preceded by DONE→IDLE. Changing sel mid-RUN does not alter load_val until the next LOAD.
- Assert reset_n low mid-RUN (after 5 shifts) → outputs return to reset values asynchronously; after release, no shift pulses occur until a new start.
- Invariant check over all runs: shift & ~load_n never true; fill always 0.
